// File: rtl/rd_resp_pkg.sv
// rd_resp_pkg -- shared definitions for the rd_responder block.
//   state_t  : responder FSM state encoding (IDLE, WAIT, DATA)
//   DW_DEF   : default read/write data width
//   AW_DEF   : default address width (2**AW storage words)
//   WCFG_W   : width of the wait-state count (wait_cfg / cnt)
package rd_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam int DW_DEF = 8;
   localparam int AW_DEF = 4;
   localparam int WCFG_W = 3;

endpackage

// File: rtl/rd_resp_mem.sv
// rd_resp_mem -- 2**AW x DW register-array storage for rd_responder.
// One synchronous write port, one asynchronous (combinational) read port.
// Because the read is combinational and the write lands on the clock edge,
// a consumer that registers rd_data on the same edge as a write to the same
// address captures the old word.
// Ports:
//   clk     : clock, writes on rising edge
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data (combinational)
// Contents are intentionally not reset.
module rd_resp_mem #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);

   logic [DW-1:0] mem [2**AW];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/rd_responder.sv
// rd_responder -- read responder with programmable wait states.
// A read starts when rd is sampled high in IDLE: addr and wait_cfg are
// latched, ws is raised for exactly wait_cfg cycles, then the word is
// registered onto rdata with rvalid high until the initiator drops rd.
// Dropping rd during the wait states aborts the read.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   rd       : read request (held until ws seen low)
//   addr     : read address, sampled at read start
//   wait_cfg : wait-state count 0..7, sampled at read start
//   wr_en    : storage write strobe
//   wr_addr  : storage write address
//   wr_data  : storage write data
//   ws       : registered wait-state flag
//   rdata    : registered read data
//   rvalid   : registered read-valid flag
//   rpar     : even parity of rdata (only with RD_RESP_PARITY_EN defined)
// Optional feature macro: RD_RESP_PARITY_EN adds the rpar output.
module rd_responder
   import rd_resp_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int AW = AW_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rd,
   input  logic [AW-1:0]     addr,
   input  logic [WCFG_W-1:0] wait_cfg,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DW-1:0]     wr_data,
   output logic              ws,
   output logic [DW-1:0]     rdata,
   output logic              rvalid
`ifdef RD_RESP_PARITY_EN
   ,
   output logic              rpar
`endif
);

   state_t            state;
   logic [WCFG_W-1:0] cnt;
   logic [AW-1:0]     addr_lat;
   logic [AW-1:0]     mem_addr;
   logic [DW-1:0]     mem_rdata;

   // Zero-wait reads load on the starting edge, before addr is latched,
   // so IDLE reads straight from the port.
   assign mem_addr = (state == IDLE) ? addr : addr_lat;

   rd_resp_mem #(
      .DW (DW),
      .AW (AW)
   ) u_mem (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (mem_addr),
      .rd_data (mem_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_lat <= '0;
         ws       <= 1'b0;
         rdata    <= '0;
         rvalid   <= 1'b0;
`ifdef RD_RESP_PARITY_EN
         rpar     <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (rd) begin
                  addr_lat <= addr;
                  if (wait_cfg != '0) begin
                     ws    <= 1'b1;
                     cnt   <= wait_cfg;
                     state <= WAIT;
                  end else begin
                     ws     <= 1'b0;
                     rdata  <= mem_rdata;
                     rvalid <= 1'b1;
`ifdef RD_RESP_PARITY_EN
                     rpar   <= ^mem_rdata;
`endif
                     state  <= DATA;
                  end
               end
            end
            WAIT: begin
               if (!rd) begin
                  // Initiator abort: rdata deliberately left untouched.
                  ws     <= 1'b0;
                  rvalid <= 1'b0;
                  cnt    <= '0;
                  state  <= IDLE;
               end else if (cnt == WCFG_W'(1)) begin
                  ws     <= 1'b0;
                  cnt    <= '0;
                  rdata  <= mem_rdata;
                  rvalid <= 1'b1;
`ifdef RD_RESP_PARITY_EN
                  rpar   <= ^mem_rdata;
`endif
                  state  <= DATA;
               end else begin
                  cnt <= cnt - WCFG_W'(1);
               end
            end
            DATA: begin
               // Holding rd high here never restarts a read; IDLE must
               // see rd low first.
               if (!rd) begin
                  rvalid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               ws     <= 1'b0;
               rvalid <= 1'b0;
               cnt    <= '0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule
